// File: rtl/lut_pc_pkg.sv
// Shared types and default widths for the programmable PC target table.
package lut_pc_pkg;
    typedef enum logic {INIT = 1'b0, READY = 1'b1} state_e;

    localparam int LUT_ADDR_W   = 4;
    localparam int LUT_TARGET_W = 10;
endpackage

// File: rtl/lut_pc_mem.sv
// DEPTH x TARGET_W register array: one synchronous write port, one combinational read port.
module lut_pc_mem #(
    parameter int ADDR_W   = 4,
    parameter int TARGET_W = 10,
    parameter int DEPTH    = 16
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [TARGET_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [TARGET_W-1:0] rdata_o
);
    logic [TARGET_W-1:0] mem_q [DEPTH];

    // No reset: the owner rewrites every entry before the table is used.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/lut_pc_prog.sv
// Runtime-programmable branch-target table: identity self-init after reset, then loader
// writes and registered lookups with write-first bypass and out-of-range reporting.
module lut_pc_prog
    import lut_pc_pkg::*;
#(
    parameter int ADDR_W   = LUT_ADDR_W,
    parameter int TARGET_W = LUT_TARGET_W,
    parameter int DEPTH    = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [TARGET_W-1:0] wr_data,
    output logic                wr_ack,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [TARGET_W-1:0] rd_target,
    output logic                rd_valid,
    output logic                rd_err,
    output logic                ready
);
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [TARGET_W-1:0] mem_wdata, mem_rdata;
    logic                wr_in_range, rd_in_range, rd_acc;
    logic                wr_ack_q, wr_ack_d, rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
    logic [TARGET_W-1:0] rd_target_q, rd_target_d;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_V;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_V;
    assign rd_acc      = (state_q == READY) && rd_en;

    lut_pc_mem #(.ADDR_W(ADDR_W), .TARGET_W(TARGET_W), .DEPTH(DEPTH)) u_mem (
        .clk_i   (Clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    // INIT owns the write port; loader traffic is ignored until READY.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        case (state_q)
            INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = TARGET_W'(init_cnt_q);
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_IDX) begin
                    state_d    = READY;
                    init_cnt_d = init_cnt_q;
                end
            end
            READY:   mem_we  = wr_en && wr_in_range;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        wr_ack_d    = (state_q == READY) && wr_en;
        rd_valid_d  = rd_acc;
        rd_err_d    = rd_acc && !rd_in_range;
        rd_target_d = rd_target_q;
        if (rd_acc) begin
            if (!rd_in_range)                        rd_target_d = '0;
            else if (wr_en && (wr_addr == rd_addr))  rd_target_d = wr_data;
            else                                     rd_target_d = mem_rdata;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            wr_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_target_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wr_ack_q    <= wr_ack_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
            rd_target_q <= rd_target_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign rd_target = rd_target_q;
    assign ready     = (state_q == READY);
endmodule
